// File: rtl/drate_mc_if.sv
// Sample/result bus of the multichannel decimator: high-rate input side,
// low-rate result strobe and engine status.
interface drate_mc_if #(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 16,
    parameter int TAPS   = 16,
    parameter int CH     = 2,
    parameter int RMAX   = 64
);
    logic [$clog2(RMAX+1)-1:0] ratio;
    logic [TAPS*CWIDTH-1:0]    coefs;
    logic                      in_valid;
    logic [CH*DWIDTH-1:0]      in;
    logic [CH*DWIDTH-1:0]      out;
    logic                      out_valid;
    logic                      busy;
    logic                      overrun;

    modport master (output ratio, coefs, in_valid, in,
                    input  out, out_valid, busy, overrun);
    modport slave  (input  ratio, coefs, in_valid, in,
                    output out, out_valid, busy, overrun);
endinterface

// File: rtl/drate_mc.sv
// Multichannel decimator: shared FIR evaluated by one time-multiplexed MAC
// only at decimation instants, runtime-clamped integer down-rate ratio.
module drate_mc #(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 16,
    parameter int TAPS   = 16,
    parameter int CH     = 2,
    parameter int RMAX   = 64,
    parameter int SLICE  = 15
) (
    input logic       clk,
    input logic       rst,
    drate_mc_if.slave bus
);
    localparam int RW  = $clog2(RMAX + 1);
    localparam int TW  = $clog2(TAPS);
    localparam int CW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW  = DWIDTH + CWIDTH;
    localparam int AW  = DWIDTH + CWIDTH + $clog2(TAPS);
    localparam int RSH = (SLICE > 0) ? SLICE - 1 : 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;

    localparam logic [RW-1:0] R_ZERO    = {RW{1'b0}};
    localparam logic [RW-1:0] R_ONE     = RW'(1);
    localparam logic [RW-1:0] R_MAX     = RW'(RMAX);
    localparam logic [TW-1:0] TAP_FIRST = {TW{1'b0}};
    localparam logic [TW-1:0] TAP_LAST  = TW'(TAPS - 1);
    localparam logic [CW-1:0] CH_FIRST  = {CW{1'b0}};
    localparam logic [CW-1:0] CH_LAST   = CW'(CH - 1);

    localparam logic signed [AW:0] RND_C  = (SLICE > 0) ? ({{AW{1'b0}}, 1'b1} << RSH) : {(AW+1){1'b0}};
    localparam logic signed [AW:0] SAT_HI = {{(AW-DWIDTH+2){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [AW:0] SAT_LO = {{(AW-DWIDTH+2){1'b1}}, {(DWIDTH-1){1'b0}}};

    // Round half up by 2^SLICE, then clamp to the sample range.
    function automatic logic signed [DWIDTH-1:0] round_sat(input logic signed [AW-1:0] a);
        logic signed [AW:0] t;
        t = ($signed({a[AW-1], a}) + RND_C) >>> SLICE;
        if (t > SAT_HI) begin
            round_sat = SAT_HI[DWIDTH-1:0];
        end else if (t < SAT_LO) begin
            round_sat = SAT_LO[DWIDTH-1:0];
        end else begin
            round_sat = t[DWIDTH-1:0];
        end
    endfunction

    logic signed [DWIDTH-1:0] dl_r      [CH][TAPS];
    logic signed [DWIDTH-1:0] dl_next_s [CH][TAPS];
    logic signed [DWIDTH-1:0] shadow_r  [CH][TAPS];
    logic signed [DWIDTH-1:0] stage_r   [CH];
    logic signed [CWIDTH-1:0] coef_s    [TAPS];

    logic [RW-1:0] phase_r;
    logic [RW-1:0] ratio_lat_r;
    logic [RW-1:0] reff_s;
    logic [RW-1:0] tc_s;
    logic          event_s;

    logic [1:0]    st_r;
    logic [CW-1:0] ch_r;
    logic [TW-1:0] tap_r;

    logic signed [DWIDTH-1:0] samp_s;
    logic signed [CWIDTH-1:0] cf_s;
    logic signed [PW-1:0]     prod_s;
    logic signed [AW-1:0]     prod_ext_s;
    logic signed [AW-1:0]     sum_s;
    logic signed [AW-1:0]     acc_r;

    logic [CH*DWIDTH-1:0] out_r;
    logic                 out_valid_r;
    logic                 busy_r;
    logic                 overrun_r;

    // Ratio clamp and terminal count; a new ratio only counts from a frame start.
    always_comb begin
        if (bus.ratio <= R_ONE) begin
            reff_s = R_ONE;
        end else if (bus.ratio > R_MAX) begin
            reff_s = R_MAX;
        end else begin
            reff_s = bus.ratio;
        end
        if (phase_r == R_ZERO) begin
            tc_s = reff_s - R_ONE;
        end else begin
            tc_s = ratio_lat_r - R_ONE;
        end
        event_s = bus.in_valid && (phase_r == tc_s);
    end

    // Next delay-line contents (incoming sample at tap 0) and coefficient unpack.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            dl_next_s[c][0] = bus.in[c*DWIDTH +: DWIDTH];
            for (int k = 1; k < TAPS; k++) begin
                dl_next_s[c][k] = dl_r[c][k-1];
            end
        end
        for (int k = 0; k < TAPS; k++) begin
            coef_s[k] = bus.coefs[k*CWIDTH +: CWIDTH];
        end
    end

    // MAC datapath; the accumulator restarts on tap 0 of every channel.
    always_comb begin
        samp_s     = shadow_r[ch_r][tap_r];
        cf_s       = coef_s[tap_r];
        prod_s     = samp_s * cf_s;
        prod_ext_s = {{(AW-PW){prod_s[PW-1]}}, prod_s};
        if (tap_r == TAP_FIRST) begin
            sum_s = prod_ext_s;
        end else begin
            sum_s = acc_r + prod_ext_s;
        end
    end

    // Delay lines, phase counter and frame ratio latch advance on every accepted sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_r        <= '{default: '0};
            phase_r     <= R_ZERO;
            ratio_lat_r <= R_ONE;
        end else if (bus.in_valid) begin
            dl_r <= dl_next_s;
            if (phase_r == R_ZERO) begin
                ratio_lat_r <= reff_s;
            end
            if (event_s) begin
                phase_r <= R_ZERO;
            end else begin
                phase_r <= phase_r + R_ONE;
            end
        end
    end

    // Engine sequencing: snapshot on event, channel-major MAC, then publish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_r    <= '{default: '0};
            stage_r     <= '{default: '0};
            st_r        <= ST_IDLE;
            ch_r        <= CH_FIRST;
            tap_r       <= TAP_FIRST;
            acc_r       <= '0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            if (event_s && (st_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (st_r)
                ST_IDLE: begin
                    if (event_s) begin
                        shadow_r <= dl_next_s;
                        ch_r     <= CH_FIRST;
                        tap_r    <= TAP_FIRST;
                        busy_r   <= 1'b1;
                        st_r     <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_r <= sum_s;
                    if (tap_r == TAP_LAST) begin
                        stage_r[ch_r] <= round_sat(sum_s);
                        tap_r         <= TAP_FIRST;
                        if (ch_r == CH_LAST) begin
                            st_r <= ST_ROUND;
                        end else begin
                            ch_r <= ch_r + CW'(1);
                        end
                    end else begin
                        tap_r <= tap_r + TW'(1);
                    end
                end
                ST_ROUND: begin
                    for (int c = 0; c < CH; c++) begin
                        out_r[c*DWIDTH +: DWIDTH] <= stage_r[c];
                    end
                    out_valid_r <= 1'b1;
                    busy_r      <= 1'b0;
                    st_r        <= ST_IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    st_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.overrun   = overrun_r;
endmodule

// File: tb/tb_drate_mc.sv
// Bench for drate_mc: two instances (SLICE=0 and SLICE=1) against a sample-history reference model.
module tb_drate_mc;
    localparam int NCH  = 2;
    localparam int NTAP = 4;
    localparam int RM   = 8;
    localparam int LAT  = NCH*NTAP + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    drate_mc_if #(.DWIDTH(16), .CWIDTH(16), .TAPS(NTAP), .CH(NCH), .RMAX(RM)) bus0 ();
    drate_mc_if #(.DWIDTH(16), .CWIDTH(16), .TAPS(NTAP), .CH(NCH), .RMAX(RM)) bus1 ();

    drate_mc #(.DWIDTH(16), .CWIDTH(16), .TAPS(NTAP), .CH(NCH), .RMAX(RM), .SLICE(0))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    drate_mc #(.DWIDTH(16), .CWIDTH(16), .TAPS(NTAP), .CH(NCH), .RMAX(RM), .SLICE(1))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_cmp = 0;
    int n_bad = 0;
    int t = 0;
    int nstrobe = 0;
    int hist [NCH][NTAP];
    int coef_v [NTAP];
    int ratio_v;
    int cnt, flen, free_at, pend_t, busy_from, busy_to, ovr_t;
    logic [31:0] pend0, pend1, exp0, exp1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    function automatic int reff(input int r);
        if (r <= 1) return 1;
        if (r > RM) return RM;
        return r;
    endfunction

    // FIR over the stored history, rounded half up by 2^sl and saturated.
    function automatic logic [15:0] expv(input int c, input int sl);
        longint acc = 0;
        for (int k = 0; k < NTAP; k++) acc += longint'(hist[c][k]) * longint'(coef_v[k]);
        if (sl > 0) acc = acc + (longint'(1) << (sl - 1));
        acc = acc >>> sl;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc[15:0];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAP; k++) hist[c][k] = 0;
        cnt = 0; flen = 1; free_at = 0; pend_t = -1;
        busy_from = 0; busy_to = -1; ovr_t = -1;
        exp0 = '0; exp1 = '0;
    endtask

    task automatic apply(input bit v, input int a, input int b);
        logic [63:0] cp;
        for (int k = 0; k < NTAP; k++) cp[k*16 +: 16] = coef_v[k][15:0];
        bus0.in_valid = v;  bus1.in_valid = v;
        bus0.in = {b[15:0], a[15:0]};  bus1.in = {b[15:0], a[15:0]};
        bus0.ratio = ratio_v[3:0];  bus1.ratio = ratio_v[3:0];
        bus0.coefs = cp;  bus1.coefs = cp;
    endtask

    task automatic check_outputs();
        bit ev, eb, eo;
        ev = (t == pend_t);
        if (ev) begin exp0 = pend0; exp1 = pend1; end
        eb = (t >= busy_from) && (t <= busy_to);
        eo = (ovr_t >= 0) && (t >= ovr_t);
        if (bus0.out_valid === 1'b1) nstrobe++;
        chk("valid0", 64'(bus0.out_valid), 64'(ev));
        chk("valid1", 64'(bus1.out_valid), 64'(ev));
        chk("busy0", 64'(bus0.busy), 64'(eb));
        chk("busy1", 64'(bus1.busy), 64'(eb));
        chk("ovr0", 64'(bus0.overrun), 64'(eo));
        chk("ovr1", 64'(bus1.overrun), 64'(eo));
        chk("out0", 64'(bus0.out), 64'(exp0));
        chk("out1", 64'(bus1.out), 64'(exp1));
    endtask

    task automatic model(input bit v, input int a, input int b);
        if (!v) return;
        for (int c = 0; c < NCH; c++)
            for (int k = NTAP-1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[0][0] = a; hist[1][0] = b;
        if (cnt == 0) flen = reff(ratio_v);
        cnt++;
        if (cnt == flen) begin
            cnt = 0;
            if (t >= free_at) begin
                pend0 = {expv(1, 0), expv(0, 0)};
                pend1 = {expv(1, 1), expv(0, 1)};
                pend_t = t + LAT; busy_from = t + 1; busy_to = t + LAT - 1; free_at = t + LAT;
            end else if (ovr_t < 0) begin
                ovr_t = t + 1;
            end
        end
    endtask

    task automatic step(input bit v, input int a, input int b);
        @(negedge clk);
        check_outputs();
        apply(v, a, b);
        model(v, a, b);
        t++;
    endtask

    task automatic feed(input int a, input int b);
        step(1'b1, a, b);
        repeat (LAT + 1) step(1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_outputs();
        t++;
        rst = 1'b0;
        apply(1'b0, 0, 0);
        #1;
        chk("rst_all0", {bus0.out, bus0.out_valid, bus0.busy, bus0.overrun}, 64'd0);
        chk("rst_all1", {bus1.out, bus1.out_valid, bus1.busy, bus1.overrun}, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    int imp_exp [3] = '{200, 400, 0};
    int rc_exp [10] = '{0, 1, 1, 1, 1, 2, 2, 2, 2, 3};
    logic [31:0] rnd_exp [3] = '{32'h00020002, 32'hffffffff, 32'h00030003};
    int rnd_in [3] = '{3, -3, 5};

    initial begin
        ratio_v = 2;
        coef_v = '{1, 2, 3, 4};
        rst = 1'b1;
        apply(1'b0, 0, 0);
        model_reset();
        #1 rst = 1'b0;
        #1;
        chk("init0", {bus0.out, bus0.out_valid, bus0.busy, bus0.overrun}, 64'd0);
        chk("init1", {bus1.out, bus1.out_valid, bus1.busy, bus1.overrun}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Impulse through coefs {1,2,3,4} at R=2.
        nstrobe = 0;
        for (int i = 0; i < 6; i++) begin
            feed((i == 0) ? 100 : 0, 0);
            if (i % 2 == 1) begin
                chk("imp_ch0", 64'(bus0.out[15:0]), 64'(imp_exp[i/2]));
                chk("imp_ch1", 64'(bus0.out[31:16]), 64'd0);
            end
        end
        chk("imp_strobes", 64'(nstrobe), 64'd3);
        chk("imp_ovr", 64'(bus0.overrun), 64'd0);

        // Saturation at both rails.
        ratio_v = 1;
        coef_v = '{32767, 32767, 32767, 32767};
        repeat (4) feed(32767, 32767);
        chk("sat_hi", 64'(bus0.out), 64'h7fff7fff);
        repeat (4) feed(-32768, -32768);
        chk("sat_lo", 64'(bus0.out), 64'h80008000);

        // Round half up with SLICE=1.
        coef_v = '{1, 0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            feed(rnd_in[i], rnd_in[i]);
            chk("round", 64'(bus1.out), 64'(rnd_exp[i]));
        end

        // Back-to-back samples at R=1 overrun the engine.
        do_reset();
        nstrobe = 0;
        for (int i = 0; i < 30; i++) step(1'b1, i * 37, -i);
        chk("ovr_set", 64'(bus0.overrun), 64'd1);
        repeat (LAT + 2) step(1'b0, 0, 0);
        chk("ovr_strobes", 64'(nstrobe), 64'd3);
        chk("ovr_sticky", 64'(bus0.overrun), 64'd1);

        // Reset in MAC cycle 5 aborts the result.
        do_reset();
        step(1'b1, 500, -500);
        repeat (4) step(1'b0, 0, 0);
        do_reset();
        nstrobe = 0;
        repeat (15) step(1'b0, 0, 0);
        chk("rst_nostrobe", 64'(nstrobe), 64'd0);

        // Ratio 2->4 mid-frame, then ratio 0 and ratio RMAX+5.
        ratio_v = 2;
        nstrobe = 0;
        for (int i = 0; i < 10; i++) begin
            feed(i + 1, -i);
            if (i == 0) ratio_v = 4;
            chk("ratio_chg", 64'(nstrobe), 64'(rc_exp[i]));
        end
        ratio_v = 0;
        nstrobe = 0;
        for (int i = 0; i < 3; i++) feed(7, 7);
        chk("ratio0", 64'(nstrobe), 64'd3);
        ratio_v = RM + 5;
        nstrobe = 0;
        for (int i = 0; i < 16; i++) begin
            feed(i, i);
            if (i == 7) chk("ratio_big_half", 64'(nstrobe), 64'd1);
        end
        chk("ratio_big", 64'(nstrobe), 64'd2);

        // Randomized traffic against the model.
        for (int seg = 0; seg < 6; seg++) begin
            repeat (LAT + 2) step(1'b0, 0, 0);
            for (int k = 0; k < NTAP; k++) coef_v[k] = int'($urandom_range(0, 65535)) - 32768;
            for (int i = 0; i < 300; i++) begin
                if (i % 50 == 0) ratio_v = int'($urandom_range(0, 15));
                step(($urandom_range(0, seg % 3 + 1) == 0),
                     int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, 65535)) - 32768);
            end
        end
        repeat (LAT + 2) step(1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
